// File: rtl/minimal3_if.sv
// -----------------------------------------------------------------------------
// minimal3_if
// Groups the conditioned-input signals of minimal3 into one bundle.
//
// Signals:
//   i   raw input level, asynchronous to the consumer clock, may glitch
//   o   debounced, synchronized level of i
//   o2  one-cycle strobe, high in the cycle o has just changed
//
// Modports:
//   master  drives the raw level and observes the conditioned outputs
//   slave   the conditioner itself: samples i, drives o and o2
// -----------------------------------------------------------------------------
interface minimal3_if;
    logic i;
    logic o;
    logic o2;

    modport master (
        output i,
        input  o,
        input  o2
    );

    modport slave (
        input  i,
        output o,
        output o2
    );
endinterface : minimal3_if

// File: rtl/minimal3.sv
// -----------------------------------------------------------------------------
// minimal3
// Single-bit input conditioner. The raw level bus.i is brought into the clk
// domain through a SYNC_STAGES-deep flip-flop chain. It is then debounced:
// the synchronized level must differ from the current output for
// DEBOUNCE_CYCLES consecutive cycles before bus.o follows it. bus.o2 pulses
// for one cycle whenever bus.o changes.
//
// Parameters:
//   SYNC_STAGES      synchronizer depth, >= 1
//   DEBOUNCE_CYCLES  consecutive differing cycles required to update o, >= 1
//
// Ports:
//   clk   system clock, all state updates on the rising edge
//   rst   synchronous, active-high reset
//   bus   minimal3_if.slave: i (raw level in), o (clean level out),
//         o2 (change strobe out); both outputs are registered
// -----------------------------------------------------------------------------
module minimal3 #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    minimal3_if.slave  bus
);

    // The counter only has to reach DEBOUNCE_CYCLES-1, because the update
    // happens on the cycle the count would otherwise step past it.
    localparam int             CNT_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   o_q;
    logic                   o_d;
    logic                   o2_q;
    logic                   o2_d;
    logic                   s_s;

    // Last synchronizer stage: the only view of the input the debouncer sees.
    assign s_s = sync_q[SYNC_STAGES-1];

    // Synchronizer shift: stage 0 samples the raw input, later stages follow.
    always_comb begin
        sync_d    = sync_q;
        sync_d[0] = bus.i;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
    end

    // Debounce decision: count consecutive disagreement, update o on the last.
    always_comb begin
        cnt_d = CNT_ZERO;
        o_d   = o_q;
        o2_d  = 1'b0;
        if (s_s == o_q) begin
            // Agreement (or a glitch ending) discards any partial count.
            cnt_d = CNT_ZERO;
            o_d   = o_q;
            o2_d  = 1'b0;
        end else if (cnt_q == CNT_MAX) begin
            cnt_d = CNT_ZERO;
            o_d   = s_s;
            o2_d  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_ONE;
            o_d   = o_q;
            o2_d  = 1'b0;
        end
    end

    // State register with synchronous reset overriding all activity.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{1'b0}};
            cnt_q  <= CNT_ZERO;
            o_q    <= 1'b0;
            o2_q   <= 1'b0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            o_q    <= o_d;
            o2_q   <= o2_d;
        end
    end

    assign bus.o  = o_q;
    assign bus.o2 = o2_q;

endmodule : minimal3

// File: tb/tb_minimal3.sv
// -----------------------------------------------------------------------------
// tb_minimal3
// Drives two conditioners (default parameters, and the single-stage /
// single-cycle variant) from one clock and reset, and checks them against a
// queue-based reference model plus fixed latency expectations.
// -----------------------------------------------------------------------------
module tb_minimal3;

    localparam int SA = 2;
    localparam int DA = 4;
    localparam int SB = 1;
    localparam int DB = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    minimal3_if bus_a ();
    minimal3_if bus_b ();

    minimal3 #(.SYNC_STAGES(SA), .DEBOUNCE_CYCLES(DA)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    minimal3 #(.SYNC_STAGES(SB), .DEBOUNCE_CYCLES(DB)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: each queue holds the raw samples still in flight
    // through the synchronizer; run_* counts consecutive disagreeing cycles.
    logic hq_a[$];
    logic hq_b[$];
    logic m_oa, m_o2a, m_ob, m_o2b;
    int   run_a, run_b;

    task automatic model_a(input logic r, input logic iv);
        logic s;
        if (r) begin
            hq_a.delete();
            for (int k = 0; k < SA; k++) hq_a.push_back(1'b0);
            run_a = 0; m_oa = 1'b0; m_o2a = 1'b0;
        end else begin
            s = hq_a.pop_front();
            hq_a.push_back(iv);
            m_o2a = 1'b0;
            if (s != m_oa) begin
                run_a++;
                if (run_a == DA) begin
                    m_oa = s; run_a = 0; m_o2a = 1'b1;
                end
            end else begin
                run_a = 0;
            end
        end
    endtask

    task automatic model_b(input logic r, input logic iv);
        logic s;
        if (r) begin
            hq_b.delete();
            for (int k = 0; k < SB; k++) hq_b.push_back(1'b0);
            run_b = 0; m_ob = 1'b0; m_o2b = 1'b0;
        end else begin
            s = hq_b.pop_front();
            hq_b.push_back(iv);
            m_o2b = 1'b0;
            if (s != m_ob) begin
                run_b++;
                if (run_b == DB) begin
                    m_ob = s; run_b = 0; m_o2b = 1'b1;
                end
            end else begin
                run_b = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, advance the model on the rising
    // edge, return 1 time unit later so outputs are sampled off the edge.
    task automatic step(input logic r, input logic ia, input logic ib);
        @(negedge clk);
        rst     = r;
        bus_a.i = ia;
        bus_b.i = ib;
        @(posedge clk);
        model_a(r, ia);
        model_b(r, ib);
        #1;
    endtask

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            step(1'b1, 1'b1, 1'b1);
            n_cmp++;
            if (bus_a.o !== 1'b0 || bus_a.o2 !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_a cyc=%0d: got o=%b o2=%b, want o=0 o2=0", k, bus_a.o, bus_a.o2);
            end
            n_cmp++;
            if (bus_b.o !== 1'b0 || bus_b.o2 !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_b cyc=%0d: got o=%b o2=%b, want o=0 o2=0", k, bus_b.o, bus_b.o2);
            end
        end
        step(1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (bus_a.o !== 1'b0 || bus_a.o2 !== 1'b0 || bus_b.o !== 1'b0 || bus_b.o2 !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_release: got a=%b/%b b=%b/%b, want all 0",
                     bus_a.o, bus_a.o2, bus_b.o, bus_b.o2);
        end
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_glitch();
        for (int k = 1; k <= 15; k++) begin
            step(1'b0, (k <= 3) ? 1'b1 : 1'b0, 1'b0);
            n_cmp++;
            if (bus_a.o !== 1'b0 || bus_a.o2 !== 1'b0) begin
                n_bad++;
                $display("FAIL glitch edge=%0d: got o=%b o2=%b, want o=0 o2=0", k, bus_a.o, bus_a.o2);
            end
        end
    endtask

    // Edge-exact check for a held level: o takes new_lvl at edge 6, o2 only there.
    task automatic test_edge(input string name, input logic new_lvl);
        logic eo, eo2;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, new_lvl, 1'b0);
            eo  = (k >= 6) ? new_lvl : ~new_lvl;
            eo2 = (k == 6) ? 1'b1 : 1'b0;
            n_cmp++;
            if (bus_a.o !== eo || bus_a.o2 !== eo2) begin
                n_bad++;
                $display("FAIL %s edge=%0d: got o=%b o2=%b, want o=%b o2=%b",
                         name, k, bus_a.o, bus_a.o2, eo, eo2);
            end
            n_cmp++;
            if (bus_a.o !== m_oa || bus_a.o2 !== m_o2a) begin
                n_bad++;
                $display("FAIL %s_model edge=%0d: got o=%b o2=%b, want o=%b o2=%b",
                         name, k, bus_a.o, bus_a.o2, m_oa, m_o2a);
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b1, 1'b0);
            n_cmp++;
            if (bus_a.o !== 1'b0) begin
                n_bad++;
                $display("FAIL rstmid_pre edge=%0d: got o=%b, want o=0", k, bus_a.o);
            end
        end
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus_a.o !== 1'b0 || bus_a.o2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rstmid_rst: got o=%b o2=%b, want o=0 o2=0", bus_a.o, bus_a.o2);
        end
        test_edge("rstmid_rise", 1'b1);
        // Reset with o high and i still high must force o back to 0.
        step(1'b1, 1'b1, 1'b0);
        n_cmp++;
        if (bus_a.o !== 1'b0 || bus_a.o2 !== 1'b0) begin
            n_bad++;
            $display("FAIL rst_from_high: got o=%b o2=%b, want o=0 o2=0", bus_a.o, bus_a.o2);
        end
    endtask

    task automatic test_single_stage();
        logic ib, prev1, prev2, eo, eo2;
        int   pulses, toggles;
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        prev1 = 1'b0; prev2 = 1'b0; pulses = 0; toggles = 0;
        for (int k = 0; k < 30; k++) begin
            ib = ((k / 3) % 2 == 1) ? 1'b1 : 1'b0;
            if (ib != prev1) toggles++;
            step(1'b0, 1'b0, ib);
            // o shows the level driven one edge earlier: 2 edges from sampling.
            eo  = prev1;
            eo2 = (prev1 != prev2) ? 1'b1 : 1'b0;
            if (bus_b.o2 === 1'b1) pulses++;
            n_cmp++;
            if (bus_b.o !== eo || bus_b.o2 !== eo2) begin
                n_bad++;
                $display("FAIL fast_track k=%0d: got o=%b o2=%b, want o=%b o2=%b",
                         k, bus_b.o, bus_b.o2, eo, eo2);
            end
            prev2 = prev1;
            prev1 = ib;
        end
        n_cmp++;
        if (pulses != toggles) begin
            n_bad++;
            $display("FAIL fast_pulses: got %0d pulses, want %0d", pulses, toggles);
        end
    endtask

    task automatic test_random();
        logic ia, ib, r;
        int   left;
        step(1'b1, 1'b0, 1'b0);
        ia = 1'b0; left = 0;
        for (int k = 0; k < 400; k++) begin
            if (left == 0) begin
                ia   = ($urandom_range(1) == 1) ? 1'b1 : 1'b0;
                left = $urandom_range(8, 1);
            end
            left--;
            ib = ($urandom_range(1) == 1) ? 1'b1 : 1'b0;
            r  = ($urandom_range(49) == 0) ? 1'b1 : 1'b0;
            step(r, ia, ib);
            n_cmp++;
            if (bus_a.o !== m_oa || bus_a.o2 !== m_o2a) begin
                n_bad++;
                $display("FAIL rand_a k=%0d: got o=%b o2=%b, want o=%b o2=%b",
                         k, bus_a.o, bus_a.o2, m_oa, m_o2a);
            end
            n_cmp++;
            if (bus_b.o !== m_ob || bus_b.o2 !== m_o2b) begin
                n_bad++;
                $display("FAIL rand_b k=%0d: got o=%b o2=%b, want o=%b o2=%b",
                         k, bus_b.o, bus_b.o2, m_ob, m_o2b);
            end
        end
    endtask

    initial begin
        bus_a.i = 1'b0;
        bus_b.i = 1'b0;
        test_reset();
        test_glitch();
        test_edge("clean_rise", 1'b1);
        test_edge("clean_fall", 1'b0);
        test_reset_mid();
        test_single_stage();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_minimal3
